// File: rtl/caravel_reset_sequencer_if.sv
// Control/status bundle for the staged reset sequencer: request inputs from
// the SPI/software side, sequenced reset outputs and status back.
interface caravel_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int GAP_W       = 4
);
  logic                   ext_reset;
  logic                   soft_req;
  logic [NUM_DOMAINS-1:0] soft_mask;
  logic [GAP_W-1:0]       cfg_gap;
  logic [NUM_DOMAINS-1:0] domain_resetb;
  logic                   seq_busy;
  logic                   seq_done;
  logic [1:0]             reset_cause;

  modport master (
    output ext_reset, soft_req, soft_mask, cfg_gap,
    input  domain_resetb, seq_busy, seq_done, reset_cause
  );

  modport slave (
    input  ext_reset, soft_req, soft_mask, cfg_gap,
    output domain_resetb, seq_busy, seq_done, reset_cause
  );
endinterface

// File: rtl/caravel_reset_sequencer.sv
// Staged reset-release controller: synchronises chip reset, stretches it, then
// releases each domain in index order with a programmable gap.
module caravel_reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int STRETCH     = 8,
  parameter int GAP_W       = 4
) (
  input logic                       ext_clk,
  input logic                       resetb,
  caravel_reset_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t                 state;
  logic [1:0]             sync_q;
  logic                   rst_sync;
  logic [7:0]             cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       nxt_idx;
  logic [GAP_W-1:0]       gap_cnt;
  logic [GAP_W-1:0]       gap_lat;
  logic [NUM_DOMAINS-1:0] scope;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             cause_q;

  assign rst_sync = sync_q[1];
  assign nxt_idx  = idx + 1'b1;

  always_ff @(posedge ext_clk or negedge resetb) begin
    if (!resetb) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], 1'b1};
  end

  always_ff @(posedge ext_clk or negedge resetb) begin
    if (!resetb) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      gap_lat <= '0;
      scope   <= '1;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b00;
    end else if (bus.ext_reset) begin
      // Held in HOLD with count 0 for as long as the SPI request stays high
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      scope   <= '1;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= 2'b01;
    end else begin
      case (state)
        HOLD: if (rst_sync) begin
          if (cnt == 8'(STRETCH-1)) begin
            state   <= RELEASE;
            gap_lat <= bus.cfg_gap;
            gap_cnt <= '0;
            idx     <= '0;
            if (scope[0]) dom_q[0] <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          // Out-of-scope indices still spend a full gap so timing is mask-independent
          if (gap_cnt == gap_lat) begin
            gap_cnt <= '0;
            idx     <= nxt_idx;
            if (scope[nxt_idx]) dom_q[nxt_idx] <= 1'b1;
            if (idx == IDX_W'(NUM_DOMAINS-2)) begin
              state  <= RUN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RUN: if (bus.soft_req && |bus.soft_mask) begin
          state   <= HOLD;
          cnt     <= '0;
          idx     <= '0;
          gap_cnt <= '0;
          scope   <= bus.soft_mask;
          dom_q   <= dom_q & ~bus.soft_mask;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          cause_q <= 2'b10;
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.domain_resetb = dom_q;
  assign bus.seq_busy      = busy_q;
  assign bus.seq_done      = done_q;
  assign bus.reset_cause   = cause_q;
endmodule

// File: tb/tb_caravel_reset_sequencer.sv
// Directed bench for caravel_reset_sequencer: POR timing, zero gap, soft and
// SPI resets, and asynchronous reset mid-sequence.
module tb_caravel_reset_sequencer;
  logic ext_clk;
  logic resetb;
  int   pass_cnt;
  int   total;

  caravel_reset_sequencer_if #(.NUM_DOMAINS(4), .GAP_W(4)) bus ();

  caravel_reset_sequencer #(.NUM_DOMAINS(4), .STRETCH(8), .GAP_W(4)) dut (
    .ext_clk (ext_clk),
    .resetb  (resetb),
    .bus     (bus)
  );

  initial begin
    ext_clk = 1'b0;
    forever #5 ext_clk = ~ext_clk;
  end

  task automatic step();
    @(posedge ext_clk);
    #1;
  endtask

  // Leaves the bench just before edge 1 (first rising edge with resetb high)
  task automatic por(input logic [3:0] gap);
    resetb        = 1'b0;
    bus.ext_reset = 1'b0;
    bus.soft_req  = 1'b0;
    bus.soft_mask = '0;
    bus.cfg_gap   = gap;
    repeat (2) @(posedge ext_clk);
    @(negedge ext_clk);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    por(4'd3);
    resetb = 1'b0;
    #1;
    total++;
    if (bus.domain_resetb !== 4'b0000 || bus.seq_busy !== 1'b1 ||
        bus.seq_done !== 1'b0 || bus.reset_cause !== 2'b00)
      $display("FAIL reset_state: dom=%b busy=%b done=%b cause=%b, want 0000 1 0 00",
               bus.domain_resetb, bus.seq_busy, bus.seq_done, bus.reset_cause);
    else pass_cnt++;
  endtask

  task automatic test_por_gap3();
    logic [3:0] exp;
    por(4'd3);
    for (int e = 1; e <= 24; e++) begin
      step();
      exp = {e >= 22, e >= 18, e >= 14, e >= 10};
      total++;
      if (bus.domain_resetb !== exp || bus.seq_done !== (e >= 22) || bus.seq_busy !== (e < 22))
        $display("FAIL por_gap3 edge %0d: dom=%b done=%b busy=%b, want dom=%b done=%b",
                 e, bus.domain_resetb, bus.seq_done, bus.seq_busy, exp, e >= 22);
      else pass_cnt++;
    end
    total++;
    if (bus.reset_cause !== 2'b00)
      $display("FAIL por_cause: got %b want 00", bus.reset_cause);
    else pass_cnt++;
  endtask

  task automatic test_gap0();
    logic [3:0] exp;
    por(4'd0);
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 11) bus.cfg_gap = 4'd5;
      exp = {e >= 13, e >= 12, e >= 11, e >= 10};
      total++;
      if (bus.domain_resetb !== exp || bus.seq_done !== (e >= 13))
        $display("FAIL gap0 edge %0d: dom=%b done=%b, want dom=%b done=%b",
                 e, bus.domain_resetb, bus.seq_done, exp, e >= 13);
      else pass_cnt++;
    end
  endtask

  // Runs from RUN left by test_gap0; new gap of 1 is latched by the soft sequence
  task automatic test_soft();
    logic [3:0] exp;
    bus.cfg_gap   = 4'd1;
    bus.soft_req  = 1'b1;
    bus.soft_mask = 4'b0000;
    step();
    bus.soft_req = 1'b0;
    total++;
    if (bus.domain_resetb !== 4'b1111 || bus.seq_done !== 1'b1 || bus.reset_cause !== 2'b00)
      $display("FAIL soft_zero_mask: dom=%b done=%b cause=%b, want 1111 1 00",
               bus.domain_resetb, bus.seq_done, bus.reset_cause);
    else pass_cnt++;

    bus.soft_req  = 1'b1;
    bus.soft_mask = 4'b0101;
    step();
    bus.soft_req  = 1'b0;
    bus.soft_mask = 4'b1111;
    total++;
    if (bus.domain_resetb !== 4'b1010 || bus.seq_busy !== 1'b1 ||
        bus.seq_done !== 1'b0 || bus.reset_cause !== 2'b10)
      $display("FAIL soft_entry: dom=%b busy=%b done=%b cause=%b, want 1010 1 0 10",
               bus.domain_resetb, bus.seq_busy, bus.seq_done, bus.reset_cause);
    else pass_cnt++;

    for (int j = 1; j <= 14; j++) begin
      step();
      exp = 4'b1010 | {1'b0, j >= 12, 1'b0, j >= 8};
      total++;
      if (bus.domain_resetb !== exp || bus.seq_done !== (j >= 14))
        $display("FAIL soft_seq E+%0d: dom=%b done=%b, want dom=%b done=%b",
                 j, bus.domain_resetb, bus.seq_done, exp, j >= 14);
      else pass_cnt++;
    end
  endtask

  task automatic test_ext();
    logic [3:0] exp;
    por(4'd3);
    repeat (19) step();
    bus.ext_reset = 1'b1;
    for (int e = 20; e <= 24; e++) begin
      if (e == 22) begin
        bus.soft_req  = 1'b1;
        bus.soft_mask = 4'b1111;
      end
      step();
      bus.soft_req = 1'b0;
      total++;
      if (bus.domain_resetb !== 4'b0000 || bus.seq_busy !== 1'b1 || bus.reset_cause !== 2'b01)
        $display("FAIL ext_hold edge %0d: dom=%b busy=%b cause=%b, want 0000 1 01",
                 e, bus.domain_resetb, bus.seq_busy, bus.reset_cause);
      else pass_cnt++;
    end
    bus.ext_reset = 1'b0;
    for (int e = 25; e <= 45; e++) begin
      if (e == 26) begin
        bus.soft_req  = 1'b1;
        bus.soft_mask = 4'b0001;
      end
      step();
      bus.soft_req = 1'b0;
      exp = {e >= 44, e >= 40, e >= 36, e >= 32};
      total++;
      if (bus.domain_resetb !== exp || bus.seq_done !== (e >= 44) || bus.reset_cause !== 2'b01)
        $display("FAIL ext_seq edge %0d: dom=%b done=%b cause=%b, want dom=%b done=%b cause=01",
                 e, bus.domain_resetb, bus.seq_done, bus.reset_cause, exp, e >= 44);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_mid();
    logic [3:0] exp;
    por(4'd3);
    repeat (15) step();
    #2 resetb = 1'b0;
    #1;
    total++;
    if (bus.domain_resetb !== 4'b0000 || bus.seq_busy !== 1'b1 || bus.seq_done !== 1'b0)
      $display("FAIL async_clear: dom=%b busy=%b done=%b, want 0000 1 0",
               bus.domain_resetb, bus.seq_busy, bus.seq_done);
    else pass_cnt++;
    por(4'd3);
    for (int e = 1; e <= 22; e++) begin
      step();
      if (e == 9 || e == 10 || e == 13 || e == 14 || e == 18 || e == 21 || e == 22) begin
        exp = {e >= 22, e >= 18, e >= 14, e >= 10};
        total++;
        if (bus.domain_resetb !== exp || bus.seq_done !== (e >= 22) || bus.reset_cause !== 2'b00)
          $display("FAIL async_repor edge %0d: dom=%b done=%b cause=%b, want dom=%b done=%b cause=00",
                   e, bus.domain_resetb, bus.seq_done, bus.reset_cause, exp, e >= 22);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset();
    test_por_gap3();
    test_gap0();
    test_soft();
    test_ext();
    test_async_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/caravel_reset_sequencer.md
# caravel_reset_sequencer

Staged reset-release controller for the management/user clock domains. It synchronises the asynchronous chip reset to `ext_clk` and holds every downstream domain in reset for a fixed stretch. It then releases the domains one at a time, in index order, with a programmable gap between releases. It also re-runs the sequence on an SPI-driven external reset, or on a masked software reset request, and reports busy/done and the cause of the last reset.

## Interface
Parameters:
- `NUM_DOMAINS`, 4: number of sequenced reset outputs (2..8).
- `STRETCH`, 8: hold cycles before the first release (2..255).
- `GAP_W`, 4: width of `cfg_gap`.

Ports:
- `ext_clk`  in  1  sole clock; all logic on rising edge.
- `resetb`  in  1  chip reset. Asynchronous assert, active-low; deassertion passes through an internal 2-flop synchroniser (`rst_sync`).
- `ext_reset`  in  1  SPI reset request, synchronous to `ext_clk`, level-sensitive, active-high.
- `soft_req`  in  1  single-cycle software reset request.
- `soft_mask`  in  NUM_DOMAINS  domains affected by `soft_req`; sampled with it.
- `cfg_gap`  in  GAP_W  extra cycles between consecutive releases; latched on entry to RELEASE.
- `domain_resetb`  out  NUM_DOMAINS  per-domain active-low resets, registered.
- `seq_busy`  out  1  high whenever state != RUN.
- `seq_done`  out  1  high in RUN.
- `reset_cause`  out  2  cause of the last sequence: 00 POR, 01 ext_reset, 10 soft.

## Operation
- States: HOLD, RELEASE, RUN.
- Async reset (`resetb` low) forces:
  - state = HOLD, hold count = 0, idx = 0, gap count = 0;
  - `domain_resetb` = all 0, `seq_busy` = 1, `seq_done` = 0, `reset_cause` = 00;
  - synchroniser flops = 0.
- HOLD:
  - All domains in scope remain asserted.
  - The counter increments each cycle while `rst_sync` = 1 and `ext_reset` = 0.
  - When the counter is STRETCH-1, the next edge goes to RELEASE, latches `cfg_gap`, sets idx = 0 and deasserts `domain_resetb[0]` if domain 0 is in scope.
- RELEASE:
  - The gap counter runs 0..cfg_gap. When it wraps, idx increments and `domain_resetb[idx]` deasserts if in scope.
  - Each index costs exactly cfg_gap+1 cycles, whether in scope or not.
  - The edge that releases idx = NUM_DOMAINS-1 also enters RUN.
- Scope: all domains after POR or ext_reset; the latched soft mask after a soft request. Out-of-scope domains keep their current value throughout.
- RUN: outputs hold. A `soft_req` with nonzero `soft_mask` does the following on the next edge:
  - latches the mask;
  - drives the masked `domain_resetb` bits to 0;
  - enters HOLD with count = 0 and sets `reset_cause` = 10.
- `soft_req` is ignored outside RUN, or when `soft_mask` = 0.
- `ext_reset` = 1 in any state, on the next edge:
  - drives all `domain_resetb` to 0;
  - enters HOLD with count = 0, sets scope to all and sets `reset_cause` = 01.
  - While `ext_reset` stays high, the count stays 0.
- Priority: async reset > ext_reset > soft_req.

## Timing
- Edge 1 is the first rising edge with `resetb` high. `rst_sync` = 1 after edge 2, and the count first increments at edge 3.
- `domain_resetb[0]` rises at edge STRETCH+2.
- `domain_resetb[k]` rises at edge STRETCH+2 + k·(cfg_gap+1).
- `seq_done` rises, and `seq_busy` falls, on the same edge as the last release.
- Soft or ext sequence: HOLD is entered on edge E. The first release is at edge E+STRETCH, then the same spacing as above.
- `resetb` low mid-sequence: all outputs return to reset values immediately, without waiting for a clock edge.
- A change of `cfg_gap` during RELEASE has no effect until the next sequence.
- `soft_req` on the RUN-exit edge (after the last release) is accepted only in the next cycle, when the state is RUN.

## Test plan
- POR with STRETCH=8, cfg_gap=3, NUM_DOMAINS=4 -> releases at edges 10, 14, 18, 22; `seq_done` = 1 at edge 22; `reset_cause` = 00.
- cfg_gap=0 -> releases on consecutive edges 10, 11, 12, 13; change `cfg_gap` to 5 at edge 11 -> spacing unchanged.
- In RUN, `soft_req` with `soft_mask` = 4'b0101 at edge E -> bits 0 and 2 drop at E, bits 1 and 3 stay 1; bit 0 rises at E+8 and bit 2 at E+8+2·(gap+1); `reset_cause` = 10. `soft_mask` = 0 -> no change.
- `ext_reset` high for 5 cycles during RELEASE (idx=2) -> all domains 0 on the next edge, count held at 0 while high, full sequence restarts after it falls; `reset_cause` = 01; a `soft_req` issued during this time is ignored.
- `resetb` pulsed low mid-RELEASE -> outputs zero asynchronously; after release, timing is identical to POR; `reset_cause` = 00.
